// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {PARITY_NONE, PARITY_EVEN, PARITY_ODD} parity_mode_e;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return (baud == 0) ? 0 : clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read: pop_data is the head whenever not empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage is left unreset so it can map onto plain register files.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed, configurable 5..9 data bits, parity, 1/2 stop bits,
// frames sent back-to-back with no idle gap.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned  CLK_FREQUENCY = 50_000_000,
  parameter int unsigned  BAUD_RATE     = 115_200,
  parameter int unsigned  DATA_BITS     = 8,
  parameter parity_mode_e PARITY_MODE   = PARITY_NONE,
  parameter int unsigned  STOP_BITS     = 1,
  parameter int unsigned  FIFO_DEPTH    = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [DATA_BITS-1:0]              data_to_transmit,
  input  logic                              request_to_send,
  output logic                              ready,
  output logic                              transmitted_bit,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQUENCY, BAUD_RATE);
  localparam int unsigned BAUD_W   = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
  localparam int unsigned BIT_W    = $clog2(DATA_BITS);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("uart_tx_buffered: CLK_FREQUENCY/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_buffered: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_buffered: FIFO_DEPTH must be a power of two >= 2");
  end

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  tx_state_e              state;
  logic [BAUD_W-1:0]      baud_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic [DATA_BITS-1:0]   head;
  logic                   par_acc;
  logic                   full, empty, pop, bit_end, last_stop;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (request_to_send),
    .push_data (data_to_transmit),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign ready     = !full;
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign last_stop = (bit_cnt == STOP_LAST);
  // Pop either from idle or on the very last stop-bit cycle, so the next start bit abuts.
  assign pop = !empty && ((state == IDLE) || (state == STOP && bit_end && last_stop));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      baud_cnt        <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      par_acc         <= 1'b0;
      transmitted_bit <= 1'b1;
      busy            <= 1'b0;
    end else begin
      if (state != IDLE) baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (!empty) begin
            state           <= START;
            transmitted_bit <= 1'b0;
            busy            <= 1'b1;
            shreg           <= head;
          end
        end
        START: begin
          if (bit_end) begin
            state           <= DATA;
            bit_cnt         <= '0;
            transmitted_bit <= shreg[0];
            par_acc         <= shreg[0];
            shreg           <= shreg >> 1;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY_MODE == PARITY_NONE) begin
                state           <= STOP;
                transmitted_bit <= 1'b1;
              end else begin
                state           <= PARITY;
                transmitted_bit <= (PARITY_MODE == PARITY_ODD) ? ~par_acc : par_acc;
              end
            end else begin
              bit_cnt         <= bit_cnt + 1'b1;
              transmitted_bit <= shreg[0];
              par_acc         <= par_acc ^ shreg[0];
              shreg           <= shreg >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state           <= STOP;
            transmitted_bit <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              bit_cnt <= '0;
              if (!empty) begin
                state           <= START;
                transmitted_bit <= 1'b0;
                shreg           <= head;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench: stimulus pushes expected frames, per-instance line monitors decode and compare.
module tb_uart_tx_buffered;
  import uart_pkg::*;

  typedef struct {
    logic [15:0] bits;
    int          len;
    longint      start;
  } frame_t;

  localparam int DIV [5] = '{434, 10, 10, 434, 16};
  localparam int NB  [5] = '{8, 7, 7, 8, 8};
  localparam int HP  [5] = '{0, 1, 1, 0, 0};
  localparam int ST  [5] = '{1, 1, 1, 2, 1};

  logic       clk;
  logic       rst  [5];
  logic       req  [5];
  logic [7:0] din  [5];
  logic       rdy  [5];
  logic       tx   [5];
  logic       busy [5];
  logic [3:0] cnt0, cnt1, cnt2, cnt3;
  logic [2:0] cnt4;

  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;
  frame_t sb [5][$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_buffered u0 (
    .clk(clk), .reset_n(rst[0]), .data_to_transmit(din[0]), .request_to_send(req[0]),
    .ready(rdy[0]), .transmitted_bit(tx[0]), .busy(busy[0]), .fifo_count(cnt0));
  uart_tx_buffered #(.CLK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                     .PARITY_MODE(PARITY_EVEN)) u1 (
    .clk(clk), .reset_n(rst[1]), .data_to_transmit(din[1][6:0]), .request_to_send(req[1]),
    .ready(rdy[1]), .transmitted_bit(tx[1]), .busy(busy[1]), .fifo_count(cnt1));
  uart_tx_buffered #(.CLK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                     .PARITY_MODE(PARITY_ODD)) u2 (
    .clk(clk), .reset_n(rst[2]), .data_to_transmit(din[2][6:0]), .request_to_send(req[2]),
    .ready(rdy[2]), .transmitted_bit(tx[2]), .busy(busy[2]), .fifo_count(cnt2));
  uart_tx_buffered #(.STOP_BITS(2)) u3 (
    .clk(clk), .reset_n(rst[3]), .data_to_transmit(din[3]), .request_to_send(req[3]),
    .ready(rdy[3]), .transmitted_bit(tx[3]), .busy(busy[3]), .fifo_count(cnt3));
  uart_tx_buffered #(.CLK_FREQUENCY(1_600_000), .BAUD_RATE(100_000), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .reset_n(rst[4]), .data_to_transmit(din[4]), .request_to_send(req[4]),
    .ready(rdy[4]), .transmitted_bit(tx[4]), .busy(busy[4]), .fifo_count(cnt4));

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected line image, bit i = i-th bit on the wire; parity bit supplied by hand.
  task automatic expect_frame(input int i, input logic [7:0] d, input bit pb, input longint start);
    frame_t e;
    e.len  = 1 + NB[i] + HP[i] + ST[i];
    e.bits = '0;
    for (int k = 0; k < NB[i]; k++) e.bits[1+k] = d[k];
    if (HP[i] != 0) e.bits[1+NB[i]] = pb;
    for (int s = 0; s < ST[i]; s++) e.bits[1+NB[i]+HP[i]+s] = 1'b1;
    e.start = start;
    sb[i].push_back(e);
  endtask

  task automatic wr(input int i, input logic [7:0] d, output longint wc, output bit acc);
    @(negedge clk);
    din[i] = d;
    req[i] = 1'b1;
    acc    = rdy[i];
    @(posedge clk);
    #1;
    wc     = cyc;
    req[i] = 1'b0;
  endtask

  // Samples the first and last cycle of every bit so a mis-sized bit period shows up.
  task automatic monitor(input int i);
    forever begin
      @(negedge clk);
      if (rst[i] === 1'b1 && tx[i] === 1'b0) begin
        logic [15:0] f, l;
        int          len;
        longint      s;
        bit          ab;
        frame_t      e;
        f   = '0;
        l   = '0;
        len = 1 + NB[i] + HP[i] + ST[i];
        s   = cyc;
        ab  = 0;
        for (int o = 0; o < len * DIV[i]; o++) begin
          if (o > 0) @(negedge clk);
          if (rst[i] !== 1'b1) begin
            ab = 1;
            break;
          end
          if (o % DIV[i] == 0)          f[o / DIV[i]] = tx[i];
          if (o % DIV[i] == DIV[i] - 1) l[o / DIV[i]] = tx[i];
        end
        if (!ab) begin
          if (sb[i].size() == 0) begin
            chk($sformatf("u%0d_unexpected_frame", i), f, 16'hffff);
          end else begin
            e = sb[i].pop_front();
            chk($sformatf("u%0d_frame_first", i), f, e.bits);
            chk($sformatf("u%0d_frame_last", i), l, e.bits);
            if (e.start >= 0) chk($sformatf("u%0d_start_cycle", i), s, e.start);
          end
        end
      end
    end
  endtask

  initial begin
    longint wc, w0;
    bit     acc, hi;
    int     n;
    for (int k = 0; k < 5; k++) begin
      req[k] = 0;
      din[k] = '0;
      rst[k] = 1'b1;
    end
    for (int k = 0; k < 5; k++) begin
      automatic int kk = k;
      fork
        monitor(kk);
      join_none
    end
    #1;
    for (int k = 0; k < 5; k++) rst[k] = 1'b0;
    #1;
    chk("rst_tx", tx[0], 1);
    chk("rst_busy", busy[0], 0);
    chk("rst_ready", rdy[0], 1);
    chk("rst_count", cnt0, 0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) rst[k] = 1'b1;

    // 8N1 0xA5: line 0,1,0,1,0,0,1,0,1,1
    wr(0, 8'hA5, wc, acc);
    chk("a5_accept", acc, 1);
    expect_frame(0, 8'hA5, 0, wc + 1);
    n = 0;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk);
      #1;
      if (busy[0]) n++;
      else if (n > 0) break;
    end
    chk("a5_busy_cycles", n, 4340);
    hi = 1;
    repeat (200) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) hi = 0;
    end
    chk("a5_idle_after", hi, 1);

    // Mid-frame asynchronous reset with a word still queued
    wr(0, 8'h3C, wc, acc);
    expect_frame(0, 8'h3C, 0, wc + 1);
    wr(0, 8'h5A, w0, acc);
    expect_frame(0, 8'h5A, 0, -1);
    chk("mid_count_before", cnt0, 1);
    repeat (1998) @(posedge clk);
    #2;
    rst[0] = 1'b0;
    #1;
    chk("mid_rst_tx", tx[0], 1);
    chk("mid_rst_count", cnt0, 0);
    chk("mid_rst_ready", rdy[0], 1);
    chk("mid_rst_busy", busy[0], 0);
    sb[0].delete();
    repeat (3) @(negedge clk);
    rst[0] = 1'b1;
    hi = 1;
    repeat (1000) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) hi = 0;
    end
    chk("post_rst_quiet", hi, 1);
    wr(0, 8'h96, wc, acc);
    expect_frame(0, 8'h96, 0, wc + 1);
    repeat (4400) @(posedge clk);

    // 7E1: 0x55 -> parity 0, 0x54 -> parity 1, 100-cycle frames
    wr(1, 8'h55, wc, acc);
    expect_frame(1, 8'h55, 0, wc + 1);
    wr(1, 8'h54, w0, acc);
    expect_frame(1, 8'h54, 1, wc + 101);
    repeat (250) @(posedge clk);
    #1;
    chk("even_count_end", cnt1, 0);

    // 7O1: 0x00 -> parity 1
    wr(2, 8'h00, wc, acc);
    expect_frame(2, 8'h00, 1, wc + 1);
    repeat (150) @(posedge clk);
    #1;
    chk("odd_count_end", cnt2, 0);

    // 8N2 back-to-back: starts at +1, +4775, +9549
    wr(3, 8'h01, w0, acc);
    expect_frame(3, 8'h01, 0, w0 + 1);
    wr(3, 8'h80, wc, acc);
    expect_frame(3, 8'h80, 0, w0 + 4775);
    wr(3, 8'hFF, wc, acc);
    expect_frame(3, 8'hFF, 0, w0 + 9549);
    chk("n2_count_2", cnt3, 2);
    repeat (4772) @(posedge clk);
    #1;
    chk("n2_count_pre_pop", cnt3, 2);
    @(posedge clk);
    #1;
    chk("n2_count_1", cnt3, 1);
    repeat (4774) @(posedge clk);
    #1;
    chk("n2_count_0", cnt3, 0);
    chk("n2_busy_held", busy[3], 1);
    repeat (4800) @(posedge clk);

    // Depth-4 overflow: 0x22..0x55 accepted, 0x66 dropped
    wr(4, 8'h11, wc, acc);
    expect_frame(4, 8'h11, 0, wc + 1);
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (busy[4]) break;
    end
    chk("d4_busy", busy[4], 1);
    for (int j = 0; j < 5; j++) begin
      automatic logic [7:0] d = 8'h22 + 8'h11 * 8'(j);
      wr(4, d, w0, acc);
      chk($sformatf("d4_ready_%0d", j), acc, (j < 4) ? 1 : 0);
      if (j < 4) expect_frame(4, d, 0, wc + 1 + 160 * (j + 1));
    end
    chk("d4_count_full", cnt4, 4);
    chk("d4_ready_low", rdy[4], 0);
    repeat (900) @(posedge clk);

    for (int k = 0; k < 5; k++) chk($sformatf("u%0d_frames_pending", k), sb[k].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
